// File: rtl/max_pool2x2_128channel_layer6.sv
// 2x2 stride-2 signed max-pool over a raster-order 128-channel pixel stream.
// Optional fused ReLU on the pooled output when MAX_POOL2X2_RELU_EN is defined.
module max_pool2x2_128channel_layer6 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int CHANNELS   = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0]   Data_In,
  input  logic                             Valid_In,
  output logic [DATA_WIDHT*CHANNELS-1:0]   Data_Out,
  output logic                             Valid_Out
);

  localparam int COL_W    = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = (IMG_WIDHT / 2 > 0) ? IMG_WIDHT / 2 : 1;
  localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam bit               COL_ODD  = (IMG_WIDHT  % 2) == 1;
  localparam bit               ROW_ODD  = (IMG_HEIGHT % 2) == 1;

  typedef logic [CHANNELS-1:0][DATA_WIDHT-1:0] pixel_t;

  pixel_t           pix_in;
  pixel_t           hold;
  pixel_t           lb_rd;
  pixel_t           max_hold_in;
  pixel_t           max_lb_in;
  pixel_t           pooled;
  pixel_t           linebuf [LB_DEPTH];
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [LB_W-1:0]  lb_idx;
  logic             in_window;

  function automatic logic [DATA_WIDHT-1:0] smax(input logic [DATA_WIDHT-1:0] a,
                                                 input logic [DATA_WIDHT-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign pix_in = Data_In;
  assign lb_idx = LB_W'(col >> 1);
  assign lb_rd  = linebuf[lb_idx];

  // A trailing odd column or row is counted but never pooled.
  assign in_window = !(COL_ODD && (col == COL_LAST)) && !(ROW_ODD && (row == ROW_LAST));

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    max_hold_in = '0;
    max_lb_in   = '0;
    pooled      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      max_hold_in[c] = smax(hold[c], pix_in[c]);
      max_lb_in[c]   = smax(pix_in[c], lb_rd[c]);
`ifdef MAX_POOL2X2_RELU_EN
      pooled[c]      = max_hold_in[c][DATA_WIDHT-1] ? '0 : max_hold_in[c];
`else
      pooled[c]      = max_hold_in[c];
`endif
    end
  end

  // Row/column position and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
    end else begin
      Valid_Out <= 1'b0;
      if (Valid_In) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_window && row[0] && col[0]) begin
          Data_Out  <= pooled;
          Valid_Out <= 1'b1;
        end
      end
    end
  end

  // NOTE: hold and line buffer carry no reset; every entry is rewritten before it is read,
  // which keeps the buffer mappable onto plain storage without a reset fan-out.
  always_ff @(posedge clk) begin
    if (Valid_In && in_window) begin
      case ({row[0], col[0]})
        2'b00:   hold            <= pix_in;
        2'b01:   linebuf[lb_idx] <= max_hold_in;
        2'b10:   hold            <= max_lb_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool2x2_128channel_layer6.sv
// Directed bench for the 2x2 max-pool: 4x4 and 5x5 frame instances driven from one initial block.
module tb_max_pool2x2_128channel_layer6;

  localparam int DW   = 32;
  localparam int CH   = 128;
  localparam int BUSW = DW * CH;

  logic            clk;
  logic            rst4, vi4, vo4;
  logic [BUSW-1:0] di4, do4;
  logic            rst5, vi5, vo5;
  logic [BUSW-1:0] di5, do5;

  logic [BUSW-1:0] pix4 [16];
  logic [BUSW-1:0] pix5 [50];
  logic [BUSW-1:0] got_data [8];
  int              got_beat [8];
  int              got_cnt;
  int              n_checks;
  int              n_pass;

  localparam logic [BUSW-1:0] IDLE_DATA = {CH{32'h7FFF_FFFF}};

  max_pool2x2_128channel_layer6 #(
    .DATA_WIDHT(DW), .IMG_WIDHT(4), .IMG_HEIGHT(4), .CHANNELS(CH)
  ) u4 (
    .clk(clk), .rst(rst4), .Data_In(di4), .Valid_In(vi4), .Data_Out(do4), .Valid_Out(vo4)
  );

  max_pool2x2_128channel_layer6 #(
    .DATA_WIDHT(DW), .IMG_WIDHT(5), .IMG_HEIGHT(5), .CHANNELS(CH)
  ) u5 (
    .clk(clk), .rst(rst5), .Data_In(di5), .Valid_In(vi5), .Data_Out(do5), .Valid_Out(vo5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ch(input logic [BUSW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // Drives nbeats pixels into one instance and records each pulse with the beat of the previous cycle.
  task automatic play(input int sel, input int nbeats, input bit gapped);
    int nslots;
    int prev_beat;
    int b;
    nslots    = gapped ? 2 * nbeats : nbeats;
    got_cnt   = 0;
    prev_beat = -1;
    b         = 0;
    for (int k = 0; k < 8; k++) begin
      got_data[k] = '0;
      got_beat[k] = -99;
    end
    for (int s = 0; s < nslots + 2; s++) begin
      @(negedge clk);
      if ((sel == 4) ? vo4 : vo5) begin
        if (got_cnt < 8) begin
          got_data[got_cnt] = (sel == 4) ? do4 : do5;
          got_beat[got_cnt] = prev_beat;
        end
        got_cnt++;
      end
      if (s < nslots && (!gapped || (s % 2) == 0)) begin
        if (sel == 4) begin
          vi4 = 1'b1;
          di4 = pix4[b];
        end else begin
          vi5 = 1'b1;
          di5 = pix5[b];
        end
        prev_beat = b;
        b++;
      end else begin
        vi4       = 1'b0;
        vi5       = 1'b0;
        di4       = IDLE_DATA;
        di5       = IDLE_DATA;
        prev_beat = -1;
      end
    end
  endtask

  task automatic fill_ramp4();
    for (int b = 0; b < 16; b++) begin
      pix4[b]             = '0;
      pix4[b][0 +: DW]    = DW'(b);
      pix4[b][127*DW +: DW] = DW'(-b);
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    rst5 = 1'b1;
    vi4  = 1'b1;
    vi5  = 1'b1;
    di4  = {CH{32'h1234_5678}};
    di5  = {CH{32'h1234_5678}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (vo4 !== 1'b0) $display("FAIL reset_valid4 cycle %0d: got %b expected 0", i, vo4);
      else n_pass++;
      n_checks++;
      if (do4 !== '0) $display("FAIL reset_data4 cycle %0d: got %0d set bits expected 0", i, $countones(do4));
      else n_pass++;
      n_checks++;
      if (vo5 !== 1'b0) $display("FAIL reset_valid5 cycle %0d: got %b expected 0", i, vo5);
      else n_pass++;
      n_checks++;
      if (do5 !== '0) $display("FAIL reset_data5 cycle %0d: got %0d set bits expected 0", i, $countones(do5));
      else n_pass++;
    end
    rst4 = 1'b0;
    rst5 = 1'b0;
    vi4  = 1'b0;
    vi5  = 1'b0;
  endtask

  task automatic check_ramp4(input string tag);
    int exp_beat [4];
    int exp0 [4];
    int exp127 [4];
    exp_beat = '{5, 7, 13, 15};
    exp0     = '{5, 7, 13, 15};
`ifdef MAX_POOL2X2_RELU_EN
    exp127   = '{0, 0, 0, 0};
`else
    exp127   = '{0, -2, -8, -10};
`endif
    n_checks++;
    if (got_cnt !== 4) $display("FAIL %s_count: got %0d pulses expected 4", tag, got_cnt);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_beat[k] !== exp_beat[k])
        $display("FAIL %s_latency%0d: pulse followed beat %0d expected beat %0d", tag, k, got_beat[k], exp_beat[k]);
      else n_pass++;
      n_checks++;
      if (ch(got_data[k], 0) !== DW'(exp0[k]))
        $display("FAIL %s_ch0_%0d: got %0d expected %0d", tag, k, $signed(ch(got_data[k], 0)), exp0[k]);
      else n_pass++;
      n_checks++;
      if (ch(got_data[k], 127) !== DW'(exp127[k]))
        $display("FAIL %s_ch127_%0d: got %0d expected %0d", tag, k, $signed(ch(got_data[k], 127)), exp127[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp4();
    play(4, 16, 1'b0);
    check_ramp4("b2b");
  endtask

  task automatic test_gapped();
    fill_ramp4();
    play(4, 16, 1'b1);
    check_ramp4("gap");
    repeat (3) @(negedge clk);
    n_checks++;
    if (ch(do4, 0) !== DW'(15)) $display("FAIL gap_hold: Data_Out ch0 got %0d expected 15", ch(do4, 0));
    else n_pass++;
    n_checks++;
    if (vo4 !== 1'b0) $display("FAIL gap_idle_valid: got %b expected 0", vo4);
    else n_pass++;
  endtask

  task automatic test_signed_compare();
    logic [DW-1:0] exp127;
    for (int b = 0; b < 16; b++) pix4[b] = '0;
    pix4[0][127*DW +: DW] = DW'(-3);
    pix4[1][127*DW +: DW] = DW'(-7);
    pix4[4][127*DW +: DW] = DW'(-1);
    pix4[5][127*DW +: DW] = DW'(-20);
    pix4[0][1*DW +: DW] = DW'(3);
    pix4[1][1*DW +: DW] = DW'(7);
    pix4[4][1*DW +: DW] = DW'(1);
    pix4[5][1*DW +: DW] = DW'(20);
    pix4[0][2*DW +: DW] = DW'(1);
    pix4[1][2*DW +: DW] = DW'(9);
    pix4[4][2*DW +: DW] = DW'(2);
    pix4[5][2*DW +: DW] = DW'(3);
`ifdef MAX_POOL2X2_RELU_EN
    exp127 = 32'h0000_0000;
`else
    exp127 = 32'hFFFF_FFFF;
`endif
    play(4, 16, 1'b0);
    n_checks++;
    if (got_cnt !== 4) $display("FAIL signed_count: got %0d pulses expected 4", got_cnt);
    else n_pass++;
    n_checks++;
    if (ch(got_data[0], 127) !== exp127)
      $display("FAIL signed_ch127: got %h expected %h", ch(got_data[0], 127), exp127);
    else n_pass++;
    n_checks++;
    if (ch(got_data[0], 1) !== DW'(20)) $display("FAIL signed_ch1: got %0d expected 20", ch(got_data[0], 1));
    else n_pass++;
    n_checks++;
    if (ch(got_data[0], 2) !== DW'(9)) $display("FAIL signed_ch2: got %0d expected 9", ch(got_data[0], 2));
    else n_pass++;
  endtask

  task automatic test_channel_isolation();
    int bad;
    for (int b = 0; b < 16; b++) pix4[b] = '0;
    for (int k = 0; k < CH; k++) pix4[0][k*DW +: DW] = DW'(k);
    play(4, 16, 1'b0);
    n_checks++;
    if (got_cnt !== 4) $display("FAIL iso_count: got %0d pulses expected 4", got_cnt);
    else n_pass++;
    bad = -1;
    for (int k = CH - 1; k >= 0; k--) if (ch(got_data[0], k) !== DW'(k)) bad = k;
    n_checks++;
    if (bad >= 0) $display("FAIL iso_first: channel %0d got %0d expected %0d", bad, ch(got_data[0], bad), bad);
    else n_pass++;
    for (int w = 1; w < 4; w++) begin
      n_checks++;
      if (got_data[w] !== '0) $display("FAIL iso_window%0d: got %0d set bits expected 0", w, $countones(got_data[w]));
      else n_pass++;
    end
  endtask

  task automatic test_odd_size_reset();
    int exp_beat [8];
    int exp0 [8];
    exp_beat = '{6, 8, 16, 18, 31, 33, 41, 43};
    exp0     = '{6, 8, 16, 18, 100, 98, 90, 88};
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      vi5 = 1'b1;
      di5 = '0;
      di5[0 +: DW] = DW'(1000 + b);
    end
    @(negedge clk);
    vi5  = 1'b0;
    rst5 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (vo5 !== 1'b0) $display("FAIL midreset_valid cycle %0d: got %b expected 0", i, vo5);
      else n_pass++;
      n_checks++;
      if (do5 !== '0) $display("FAIL midreset_data cycle %0d: got %0d set bits expected 0", i, $countones(do5));
      else n_pass++;
    end
    rst5 = 1'b0;
    for (int b = 0; b < 25; b++) begin
      pix5[b]           = '0;
      pix5[b][0 +: DW]  = DW'(b);
      pix5[b + 25]          = '0;
      pix5[b + 25][0 +: DW] = DW'(100 - b);
    end
    play(5, 50, 1'b0);
    n_checks++;
    if (got_cnt !== 8) $display("FAIL odd_count: got %0d pulses expected 8", got_cnt);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (got_beat[k] !== exp_beat[k])
        $display("FAIL odd_latency%0d: pulse followed beat %0d expected beat %0d", k, got_beat[k], exp_beat[k]);
      else n_pass++;
      n_checks++;
      if (ch(got_data[k], 0) !== DW'(exp0[k]))
        $display("FAIL odd_ch0_%0d: got %0d expected %0d", k, ch(got_data[k], 0), exp0[k]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    got_cnt  = 0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_signed_compare();
    test_channel_isolation();
    test_odd_size_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
